mem_port_arbiter: RTL and testbench

Two-port memory arbiter placed between the CPU datapath's memory strobes (`rd`/`wr` with MAR/MDR) and the single-ported program/data memory, sharing that memory with a DMA/loader port. Grants one requester at a time with round-robin fairness, drives the memory for a fixed number of wait cycles, then latches read data and returns a one-cycle `ready` pulse that the CPU controller uses as its stall release.

---
 rtl/cpu_bus_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/rr_pick2.sv | 23 ++
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the CPU/DMA memory port arbiter.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  // Wait counter width; covers WAIT up to 15.
  localparam int unsigned WCNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the memory.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);

  logic          cpu_rd;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;

  logic          dma_rd;
  logic          dma_wr;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] dma_rdata;
  logic          dma_ready;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  dma_rd, dma_wr, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ready, dma_rdata, dma_ready,
    output mem_addr, mem_wdata, mem_rd, mem_wr
  );

  // Requester and memory side.
  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output dma_rd, dma_wr, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ready, dma_rdata, dma_ready,
    input  mem_addr, mem_wdata, mem_rd, mem_wr
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-request round-robin selector: on a tie, grants the port not served last.
module rr_pick2
  import cpu_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Pick the single requester, or alternate away from the last owner on a tie.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_CPU;
    case (req)
      2'b01:   gnt_id = PORT_CPU;
      2'b10:   gnt_id = PORT_DMA;
      2'b11:   gnt_id = (last == PORT_CPU) ? PORT_DMA : PORT_CPU;
      default: gnt_id = PORT_CPU;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-ported memory between the CPU and DMA ports: round-robin
// grant, fixed WAIT-cycle access, then a one-cycle ready pulse to the owner.
module mem_port_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int unsigned AW   = 16,
  parameter int unsigned DW   = 16,
  parameter int unsigned WAIT = 2
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAIT - 1);

  state_t              state_q;
  logic                owner_q;
  logic                last_q;
  op_t                 op_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [AW-1:0]       mem_addr_q;
  logic [DW-1:0]       mem_wdata_q;
  logic                mem_rd_q;
  logic                mem_wr_q;
  logic [DW-1:0]       cpu_rdata_q;
  logic [DW-1:0]       dma_rdata_q;
  logic                cpu_ready_q;
  logic                dma_ready_q;

  logic [1:0]          req;
  logic                gnt_valid;
  logic                gnt_id;
  logic [AW-1:0]       sel_addr;
  logic [DW-1:0]       sel_wdata;
  op_t                 sel_op;

  assign req = {bus.dma_rd | bus.dma_wr, bus.cpu_rd | bus.cpu_wr};

  rr_pick2 u_pick (
    .req       (req),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Route the granted port's request; write wins when rd and wr are both high.
  always_comb begin
    sel_addr  = bus.cpu_addr;
    sel_wdata = bus.cpu_wdata;
    sel_op    = bus.cpu_wr ? OP_WR : OP_RD;
    if (gnt_id == PORT_DMA) begin
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
      sel_op    = bus.dma_wr ? OP_WR : OP_RD;
    end
  end

  // Arbiter FSM: grant and latch, hold the strobe for WAIT cycles, pulse ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= PORT_CPU;
      last_q      <= PORT_DMA;
      op_q        <= OP_RD;
      wcnt_q      <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dma_ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            owner_q     <= gnt_id;
            op_q        <= sel_op;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
            mem_rd_q    <= (sel_op == OP_RD);
            mem_wr_q    <= (sel_op == OP_WR);
            wcnt_q      <= WCNT_INIT;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (wcnt_q == '0) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            if (op_q == OP_RD) begin
              if (owner_q == PORT_DMA) dma_rdata_q <= bus.mem_rdata;
              else                     cpu_rdata_q <= bus.mem_rdata;
            end
            cpu_ready_q <= (owner_q == PORT_CPU);
            dma_ready_q <= (owner_q == PORT_DMA);
            last_q      <= owner_q;
            state_q     <= RESP;
          end else begin
            wcnt_q <= wcnt_q - WCNT_W'(1);
          end
        end
        RESP: begin
          cpu_ready_q <= 1'b0;
          dma_ready_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_ready = cpu_ready_q;
  assign bus.dma_ready = dma_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 16;
  localparam int unsigned WAIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT(WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;
  int viol   = 0;

  // Reference model: who was served last and what each port's rdata should hold.
  int            last_srv;
  logic [DW-1:0] exp_rd [2];

  typedef struct {
    int            rd_cnt;
    int            wr_cnt;
    int            ready_k;
    int            ready_port;
    int            ready_w;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            addr_stable;
    logic [DW-1:0] rdata;
  } obs_t;

  // Overlapping strobes or simultaneous ready pulses are never legal.
  always @(negedge clk) begin
    if ((bus.mem_rd && bus.mem_wr) || (bus.cpu_ready && bus.dma_ready)) viol++;
  end

  function automatic int pick(bit c, bit d);
    if (c && d) return 1 - last_srv;
    return d ? 1 : 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Observes one transaction whose grant edge is the next posedge; returns
  // positioned just before the following arbitration edge.
  task automatic watch(input logic [DW-1:0] memval, input bit drop, output obs_t o);
    o = '{default: 0};
    o.ready_k     = -1;
    o.ready_port  = -1;
    o.addr_stable = 1'b1;
    bus.mem_rdata = memval;
    for (int k = 1; k <= int'(WAIT) + 2; k++) begin
      tick;
      if (bus.mem_rd || bus.mem_wr) begin
        if (o.rd_cnt + o.wr_cnt == 0) begin
          o.addr  = bus.mem_addr;
          o.wdata = bus.mem_wdata;
        end else if (bus.mem_addr !== o.addr || bus.mem_wdata !== o.wdata) begin
          o.addr_stable = 1'b0;
        end
      end
      if (bus.mem_rd) o.rd_cnt++;
      if (bus.mem_wr) o.wr_cnt++;
      if (bus.cpu_ready || bus.dma_ready) begin
        o.ready_w++;
        if (o.ready_k < 0) begin
          o.ready_k    = k;
          o.ready_port = bus.dma_ready ? 1 : 0;
          o.rdata      = bus.dma_ready ? bus.dma_rdata : bus.cpu_rdata;
        end
      end
      if (drop && k == 1) begin
        bus.cpu_addr  = ~bus.cpu_addr;
        bus.cpu_wdata = ~bus.cpu_wdata;
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    obs_t          o;
    logic [DW-1:0] val;
    bus.cpu_rd = 1'b1; bus.cpu_wr = 1'b0; bus.cpu_addr = 16'h0011; bus.cpu_wdata = '0;
    bus.dma_rd = 1'b1; bus.dma_wr = 1'b0; bus.dma_addr = 16'h0022; bus.dma_wdata = '0;
    bus.mem_rdata = 16'hFFFF;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({bus.mem_rd, bus.mem_wr} !== 2'b00)
        $display("FAIL reset.strobes got %b want 00", {bus.mem_rd, bus.mem_wr});
      else passed++;
      checks++;
      if ({bus.cpu_ready, bus.dma_ready, bus.cpu_rdata, bus.dma_rdata, bus.mem_addr, bus.mem_wdata} !== '0)
        $display("FAIL reset.outputs got rdy=%b%b crd=%h drd=%h addr=%h wd=%h want all 0",
                 bus.cpu_ready, bus.dma_ready, bus.cpu_rdata, bus.dma_rdata, bus.mem_addr, bus.mem_wdata);
      else passed++;
    end
    rst = 1'b1;
    last_srv  = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    val = DW'($urandom);
    watch(val, 1'b0, o);
    checks++;
    if (o.ready_port !== pick(1'b1, 1'b1))
      $display("FAIL reset.first_grant got %0d want %0d", o.ready_port, pick(1'b1, 1'b1));
    else passed++;
    last_srv  = 0;
    exp_rd[0] = val;
    bus.cpu_rd = 1'b0;
    bus.dma_rd = 1'b0;
  endtask

  task automatic test_cpu_read;
    obs_t o;
    bus.cpu_addr = 16'h0040;
    bus.cpu_rd   = 1'b1;
    watch(16'hBEEF, 1'b0, o);
    bus.cpu_rd = 1'b0;
    checks++;
    if (o.rd_cnt !== int'(WAIT) || o.wr_cnt !== 0)
      $display("FAIL cpu_read.strobe got rd=%0d wr=%0d want rd=%0d wr=0", o.rd_cnt, o.wr_cnt, WAIT);
    else passed++;
    checks++;
    if (o.addr !== 16'h0040) $display("FAIL cpu_read.addr got %h want 0040", o.addr);
    else passed++;
    checks++;
    if (o.ready_k !== int'(WAIT) + 1 || o.ready_port !== 0 || o.ready_w !== 1)
      $display("FAIL cpu_read.ready got k=%0d port=%0d w=%0d want k=%0d port=0 w=1",
               o.ready_k, o.ready_port, o.ready_w, WAIT + 1);
    else passed++;
    checks++;
    if (o.rdata !== 16'hBEEF) $display("FAIL cpu_read.rdata got %h want beef", o.rdata);
    else passed++;
    last_srv  = 0;
    exp_rd[0] = 16'hBEEF;
  endtask

  task automatic test_dma_write;
    obs_t o;
    bus.dma_addr  = 16'h1234;
    bus.dma_wdata = 16'h00A5;
    bus.dma_wr    = 1'b1;
    watch(DW'($urandom), 1'b0, o);
    bus.dma_wr = 1'b0;
    checks++;
    if (o.wr_cnt !== int'(WAIT) || o.rd_cnt !== 0)
      $display("FAIL dma_write.strobe got rd=%0d wr=%0d want rd=0 wr=%0d", o.rd_cnt, o.wr_cnt, WAIT);
    else passed++;
    checks++;
    if (o.addr !== 16'h1234 || o.wdata !== 16'h00A5 || !o.addr_stable)
      $display("FAIL dma_write.bus got addr=%h wd=%h stable=%0d want 1234/00a5/1", o.addr, o.wdata, o.addr_stable);
    else passed++;
    checks++;
    if (o.ready_port !== 1 || o.ready_w !== 1 || o.ready_k !== int'(WAIT) + 1)
      $display("FAIL dma_write.ready got port=%0d w=%0d k=%0d want 1/1/%0d", o.ready_port, o.ready_w, o.ready_k, WAIT + 1);
    else passed++;
    checks++;
    if (bus.dma_rdata !== exp_rd[1]) $display("FAIL dma_write.rdata got %h want %h", bus.dma_rdata, exp_rd[1]);
    else passed++;
    last_srv = 1;
  endtask

  task automatic test_contention;
    obs_t          o;
    logic [DW-1:0] val;
    int            ep;
    int            v0;
    v0 = viol;
    bus.cpu_addr = AW'($urandom);
    bus.dma_addr = AW'($urandom);
    bus.cpu_rd   = 1'b1;
    bus.dma_rd   = 1'b1;
    for (int t = 0; t < 4; t++) begin
      ep  = pick(1'b1, 1'b1);
      val = DW'($urandom);
      watch(val, 1'b0, o);
      checks++;
      if (o.ready_port !== ep || o.ready_w !== 1 || o.rd_cnt !== int'(WAIT))
        $display("FAIL contention.grant%0d got port=%0d w=%0d rd=%0d want %0d/1/%0d",
                 t, o.ready_port, o.ready_w, o.rd_cnt, ep, WAIT);
      else passed++;
      checks++;
      if (o.addr !== (ep == 1 ? bus.dma_addr : bus.cpu_addr) || o.rdata !== val)
        $display("FAIL contention.data%0d got addr=%h rd=%h want addr=%h rd=%h",
                 t, o.addr, o.rdata, (ep == 1 ? bus.dma_addr : bus.cpu_addr), val);
      else passed++;
      last_srv   = ep;
      exp_rd[ep] = val;
    end
    bus.cpu_rd = 1'b0;
    bus.dma_rd = 1'b0;
    checks++;
    if (viol !== v0) $display("FAIL contention.overlap got %0d want 0", viol - v0);
    else passed++;
  endtask

  task automatic test_mid_access;
    obs_t          o;
    logic [AW-1:0] a;
    logic [DW-1:0] val;
    a   = AW'($urandom);
    val = DW'($urandom);
    bus.cpu_addr = a;
    bus.cpu_rd   = 1'b1;
    watch(val, 1'b1, o);
    checks++;
    if (o.addr !== a || !o.addr_stable || o.rd_cnt !== int'(WAIT))
      $display("FAIL mid_access.addr got %h stable=%0d rd=%0d want %h/1/%0d", o.addr, o.addr_stable, o.rd_cnt, a, WAIT);
    else passed++;
    checks++;
    if (o.ready_port !== 0 || o.ready_w !== 1 || o.rdata !== val)
      $display("FAIL mid_access.ready got port=%0d w=%0d rd=%h want 0/1/%h", o.ready_port, o.ready_w, o.rdata, val);
    else passed++;
    last_srv  = 0;
    exp_rd[0] = val;
  endtask

  task automatic test_back_to_back;
    obs_t          o;
    bit            c, d, w;
    int            ep;
    logic [1:0]    cop, dop;
    logic [DW-1:0] val;
    int            v0;
    v0 = viol;
    for (int t = 0; t < 24; t++) begin
      c = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      if (!c && !d) c = 1'b1;
      cop = c ? 2'($urandom_range(1, 3)) : 2'b00;
      dop = d ? 2'($urandom_range(1, 3)) : 2'b00;
      {bus.cpu_wr, bus.cpu_rd} = cop;
      {bus.dma_wr, bus.dma_rd} = dop;
      bus.cpu_addr  = AW'($urandom);
      bus.dma_addr  = AW'($urandom);
      bus.cpu_wdata = DW'($urandom);
      bus.dma_wdata = DW'($urandom);
      ep  = pick(c, d);
      w   = (ep == 1) ? dop[1] : cop[1];
      val = DW'($urandom);
      watch(val, 1'b0, o);
      checks++;
      if (o.ready_port !== ep || o.ready_k !== int'(WAIT) + 1 || o.ready_w !== 1)
        $display("FAIL b2b.ready%0d got port=%0d k=%0d w=%0d want %0d/%0d/1", t, o.ready_port, o.ready_k, o.ready_w, ep, WAIT + 1);
      else passed++;
      checks++;
      if (o.rd_cnt !== (w ? 0 : int'(WAIT)) || o.wr_cnt !== (w ? int'(WAIT) : 0))
        $display("FAIL b2b.op%0d got rd=%0d wr=%0d want write=%0d", t, o.rd_cnt, o.wr_cnt, w);
      else passed++;
      checks++;
      if (o.addr !== (ep == 1 ? bus.dma_addr : bus.cpu_addr) || o.wdata !== (ep == 1 ? bus.dma_wdata : bus.cpu_wdata))
        $display("FAIL b2b.bus%0d got addr=%h wd=%h want addr=%h wd=%h", t, o.addr, o.wdata,
                 (ep == 1 ? bus.dma_addr : bus.cpu_addr), (ep == 1 ? bus.dma_wdata : bus.cpu_wdata));
      else passed++;
      if (!w) exp_rd[ep] = val;
      last_srv = ep;
      checks++;
      if (o.rdata !== exp_rd[ep] || bus.cpu_rdata !== exp_rd[0] || bus.dma_rdata !== exp_rd[1])
        $display("FAIL b2b.rdata%0d got rdy=%h cpu=%h dma=%h want rdy=%h cpu=%h dma=%h", t,
                 o.rdata, bus.cpu_rdata, bus.dma_rdata, exp_rd[ep], exp_rd[0], exp_rd[1]);
      else passed++;
      {bus.cpu_wr, bus.cpu_rd} = 2'b00;
      {bus.dma_wr, bus.dma_rd} = 2'b00;
    end
    checks++;
    if (viol !== v0) $display("FAIL b2b.overlap got %0d want 0", viol - v0);
    else passed++;
  endtask

  task automatic test_reset_mid;
    obs_t          o;
    logic [DW-1:0] val;
    bus.cpu_addr  = AW'($urandom);
    bus.cpu_rd    = 1'b1;
    bus.mem_rdata = DW'($urandom);
    tick;
    checks++;
    if (bus.mem_rd !== 1'b1) $display("FAIL reset_mid.started got mem_rd=%b want 1", bus.mem_rd);
    else passed++;
    tick;
    rst        = 1'b0;
    bus.cpu_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({bus.mem_rd, bus.mem_wr, bus.cpu_ready, bus.dma_ready} !== 4'b0000)
        $display("FAIL reset_mid.quiet%0d got rd=%b wr=%b crdy=%b drdy=%b want 0000",
                 i, bus.mem_rd, bus.mem_wr, bus.cpu_ready, bus.dma_ready);
      else passed++;
    end
    rst       = 1'b1;
    last_srv  = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    checks++;
    if (bus.cpu_rdata !== exp_rd[0] || bus.dma_rdata !== exp_rd[1])
      $display("FAIL reset_mid.rdata got cpu=%h dma=%h want 0/0", bus.cpu_rdata, bus.dma_rdata);
    else passed++;
    bus.cpu_rd = 1'b1;
    bus.dma_rd = 1'b1;
    val = DW'($urandom);
    watch(val, 1'b0, o);
    checks++;
    if (o.ready_port !== pick(1'b1, 1'b1) || o.rdata !== val)
      $display("FAIL reset_mid.regrant got port=%0d rd=%h want %0d/%h", o.ready_port, o.rdata, pick(1'b1, 1'b1), val);
    else passed++;
    bus.cpu_rd = 1'b0;
    bus.dma_rd = 1'b0;
  endtask

  initial begin
    test_reset;
    test_cpu_read;
    test_dma_write;
    test_contention;
    test_mid_access;
    test_back_to_back;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
